ads1281_sinc3_decimator: RTL and testbench

ADS1281_SINC3_DECIMATOR -- requirements
Module: ads1281_sinc3_decimator

---
 rtl/ads1281_sinc3_decimator.sv | 139 +++++++++++++
 tb/tb_ads1281_sinc3_decimator.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ads1281_sinc3_decimator.sv
// Parallel-channel sinc3 decimator for ADS1281 M0/M1 modulator bitstreams.
// Integrators advance per strobe; combs run one clk after a decimation event.
module ads1281_sinc3_decimator #(
  parameter int NUM_CH     = 2,
  parameter int DEC_LOG2   = 6,
  parameter int DATA_WIDTH = 24
) (
  input  logic                         clk_i,
  input  logic                         rst_asy_i,
  input  logic                         m_en_i,
  input  logic [NUM_CH-1:0]            m0_i,
  input  logic [NUM_CH-1:0]            m1_i,
  input  logic                         sync_i,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_o,
  output logic                         data_en_o,
  output logic                         settled_o
);
  localparam int W     = 3 + 3 * DEC_LOG2;
  localparam int SHIFT = DATA_WIDTH - W;

  if (DATA_WIDTH < W) begin : g_width_check
    $error("DATA_WIDTH must be >= 3 + 3*DEC_LOG2");
  end

  logic                stb;
  logic                evt;
  logic [DEC_LOG2-1:0] ctr_q, ctr_d;
  logic [1:0]          settle_q, settle_d;
  logic                evt_q, evt_d;
  logic                emit_q, emit_d;
  logic                en_q, en_d;

  // sync wins over a coincident strobe
  assign stb = m_en_i & ~sync_i;
  assign evt = stb & (ctr_q == {DEC_LOG2{1'b1}});

  always_comb begin
    ctr_d    = ctr_q;
    settle_d = settle_q;
    evt_d    = 1'b0;
    emit_d   = 1'b0;
    en_d     = evt_q & emit_q;
    if (stb) ctr_d = ctr_q + 1'b1;
    if (evt) begin
      evt_d  = 1'b1;
      emit_d = (settle_q == 2'd3);
      if (settle_q != 2'd3) settle_d = settle_q + 2'd1;
    end
    if (sync_i) begin
      ctr_d    = '0;
      settle_d = '0;
      evt_d    = 1'b0;
      emit_d   = 1'b0;
      en_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_asy_i) begin
    if (rst_asy_i) begin
      ctr_q    <= '0;
      settle_q <= '0;
      evt_q    <= 1'b0;
      emit_q   <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      ctr_q    <= ctr_d;
      settle_q <= settle_d;
      evt_q    <= evt_d;
      emit_q   <= emit_d;
      en_q     <= en_d;
    end
  end

  assign data_en_o = en_q;
  assign settled_o = (settle_q == 2'd3);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic signed [2:0]     s0, s1, s0z_q, s1z_q, dec;
    logic signed [W-1:0]   i1_q, i2_q, i3_q, i1_d, i2_d, i3_d;
    logic signed [W-1:0]   cap_q, cz1_q, cz2_q, cz3_q, c1, c2, c3;
    logic [DATA_WIDTH-1:0] dat_q;

    // integrator-3 next value already contains this strobe, so it is what gets captured
    always_comb begin
      s0   = m0_i[k] ? 3'sb001 : 3'sb111;
      s1   = m1_i[k] ? 3'sb001 : 3'sb111;
      dec  = s0z_q + s1 - s1z_q;
      i1_d = i1_q + {{(W-3){dec[2]}}, dec};
      i2_d = i2_q + i1_d;
      i3_d = i3_q + i2_d;
      c1   = cap_q - cz1_q;
      c2   = c1 - cz2_q;
      c3   = c2 - cz3_q;
    end

    always_ff @(posedge clk_i or posedge rst_asy_i) begin
      if (rst_asy_i) begin
        s0z_q <= '0;
        s1z_q <= '0;
        i1_q  <= '0;
        i2_q  <= '0;
        i3_q  <= '0;
        cap_q <= '0;
        cz1_q <= '0;
        cz2_q <= '0;
        cz3_q <= '0;
        dat_q <= '0;
      end else if (sync_i) begin
        s0z_q <= '0;
        s1z_q <= '0;
        i1_q  <= '0;
        i2_q  <= '0;
        i3_q  <= '0;
        cap_q <= '0;
        cz1_q <= '0;
        cz2_q <= '0;
        cz3_q <= '0;
      end else begin
        if (stb) begin
          s0z_q <= s0;
          s1z_q <= s1;
          i1_q  <= i1_d;
          i2_q  <= i2_d;
          i3_q  <= i3_d;
          if (evt) cap_q <= i3_d;
        end
        if (evt_q) begin
          cz1_q <= cap_q;
          cz2_q <= c1;
          cz3_q <= c2;
          dat_q <= DATA_WIDTH'(c3) << SHIFT;
        end
      end
    end

    assign data_o[k*DATA_WIDTH +: DATA_WIDTH] = dat_q;
  end

endmodule

// File: tb/tb_ads1281_sinc3_decimator.sv
// Bench for ads1281_sinc3_decimator: direct sinc3 FIR reference model feeding a scoreboard.
module tb_ads1281_sinc3_decimator;
  localparam int NUM_CH   = 2;
  localparam int DEC_LOG2 = 6;
  localparam int DW       = 24;
  localparam int R        = 1 << DEC_LOG2;
  localparam int W        = 3 + 3 * DEC_LOG2;
  localparam int HL       = 3 * R - 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 m_en;
  logic                 sync;
  logic [NUM_CH-1:0]    m0, m1;
  logic [NUM_CH*DW-1:0] data;
  logic                 data_en;
  logic                 settled;

  always #5 clk = ~clk;

  ads1281_sinc3_decimator #(.NUM_CH(NUM_CH), .DEC_LOG2(DEC_LOG2), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_asy_i(rst), .m_en_i(m_en), .m0_i(m0), .m1_i(m1),
    .sync_i(sync), .data_o(data), .data_en_o(data_en), .settled_o(settled)
  );

  typedef struct {
    longint               cyc;
    logic [NUM_CH*DW-1:0] dat;
  } exp_t;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     n_words  = 0;
  longint cyc      = 0;
  int     h[HL];
  int     t2[2*R-1];
  int     hist[NUM_CH][$];
  int     ms0z[NUM_CH];
  int     ms1z[NUM_CH];
  int     mctr, msettle;
  exp_t   sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      ms0z[c] = 0;
      ms1z[c] = 0;
      hist[c].delete();
    end
    mctr    = 0;
    msettle = 0;
  endfunction

  // reference: decoded samples convolved with the sinc3 kernel at each decimation point
  function automatic void model_step(input logic [NUM_CH-1:0] b0, input logic [NUM_CH-1:0] b1);
    exp_t e;
    for (int c = 0; c < NUM_CH; c++) begin
      int s0, s1, d;
      s0 = b0[c] ? 1 : -1;
      s1 = b1[c] ? 1 : -1;
      d  = ms0z[c] + s1 - ms1z[c];
      hist[c].push_front(d);
      if (hist[c].size() > HL) void'(hist[c].pop_back());
      ms0z[c] = s0;
      ms1z[c] = s1;
    end
    if (mctr == R - 1) begin
      e.cyc = cyc + 2;
      e.dat = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        longint     y;
        logic [63:0] t;
        y = 0;
        for (int k = 0; k < hist[c].size(); k++) y += longint'(h[k]) * longint'(hist[c][k]);
        t = 64'(y) << (DW - W);
        e.dat[c*DW +: DW] = t[DW-1:0];
      end
      if (msettle == 3) sb.push_back(e);
      else msettle++;
    end
    mctr = (mctr + 1) % R;
  endfunction

  // advance one clk; scoreboard pops on data_en_o at the mid-cycle sample point
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (data_en === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_data_en: data_en_o=1 at cyc %0d, required no strobe", cyc);
      end else begin
        e = sb.pop_front();
        n_words++;
        if (data !== e.dat || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL word: got data_o=%h at cyc %0d, required %h at cyc %0d", data, cyc, e.dat, e.cyc);
        end
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL missing_data_en: data_en_o=0 at cyc %0d, required word %h", cyc, sb[0].dat);
      void'(sb.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [NUM_CH-1:0] b0, input logic [NUM_CH-1:0] b1, input int gap);
    m0   = b0;
    m1   = b1;
    m_en = 1'b1;
    model_step(b0, b1);
    tick();
    m_en = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic do_sync(input logic with_stb);
    sync = 1'b1;
    m_en = with_stb;
    while (sb.size() > 0 && sb[sb.size()-1].cyc > cyc) void'(sb.pop_back());
    model_clear();
    tick();
    sync = 1'b0;
    m_en = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; m_en = 1'b0; sync = 1'b0; m0 = '0; m1 = '0;
    #2;
    n_checks++; if (data !== '0)   begin n_fail++; $display("FAIL reset_data: got %h, required 0", data); end
    n_checks++; if (data_en !== 0) begin n_fail++; $display("FAIL reset_en: got %b, required 0", data_en); end
    n_checks++; if (settled !== 0) begin n_fail++; $display("FAIL reset_settled: got %b, required 0", settled); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    repeat (2) tick();
  endtask

  task automatic test_all_ones();
    int w0;
    do_sync(1'b0);
    w0 = n_words;
    for (int i = 0; i < 7 * R; i++) begin
      strobe('1, '1, 4);
      if (i == 2 * R - 1) begin
        n_checks++; if (settled !== 1'b0) begin n_fail++; $display("FAIL ones_settled_early: got %b, required 0", settled); end
      end
      if (i == 3 * R - 1) begin
        n_checks++; if (settled !== 1'b1) begin n_fail++; $display("FAIL ones_settled: got %b, required 1", settled); end
      end
    end
    repeat (4) tick();
    n_checks++; if (n_words - w0 != 4) begin n_fail++; $display("FAIL ones_word_count: got %0d, required 4", n_words - w0); end
    n_checks++; if (data !== {NUM_CH{24'h200000}}) begin n_fail++; $display("FAIL ones_value: got %h, required %h", data, {NUM_CH{24'h200000}}); end
  endtask

  task automatic test_opposite();
    int w0;
    do_sync(1'b0);
    w0 = n_words;
    for (int i = 0; i < 5 * R; i++) strobe(2'b01, 2'b01, 4);
    repeat (4) tick();
    n_checks++; if (n_words - w0 != 2) begin n_fail++; $display("FAIL opp_word_count: got %0d, required 2", n_words - w0); end
    n_checks++; if (data !== {24'hE00000, 24'h200000}) begin n_fail++; $display("FAIL opp_value: got %h, required e00000200000", data); end
  endtask

  task automatic test_toggle();
    logic tog;
    do_sync(1'b0);
    tog = 1'b1;
    for (int i = 0; i < 5 * R; i++) begin
      strobe('1, {NUM_CH{tog}}, 3);
      tog = ~tog;
    end
    repeat (4) tick();
    n_checks++; if (data !== {NUM_CH{24'h200000}}) begin n_fail++; $display("FAIL toggle_value: got %h, required %h", data, {NUM_CH{24'h200000}}); end
  endtask

  task automatic test_random();
    int w0;
    do_sync(1'b0);
    w0 = n_words;
    for (int i = 0; i < 6 * R; i++)
      strobe(NUM_CH'($urandom), NUM_CH'($urandom), int'($urandom_range(3, 6)));
    repeat (4) tick();
    n_checks++; if (n_words - w0 != 3) begin n_fail++; $display("FAIL random_word_count: got %0d, required 3", n_words - w0); end
  endtask

  task automatic test_sync();
    logic [NUM_CH*DW-1:0] held;
    int w0;
    for (int i = 0; i < 99; i++) strobe(NUM_CH'($urandom), NUM_CH'($urandom), 4);
    n_checks++; if (settled !== 1'b1) begin n_fail++; $display("FAIL sync_pre_settled: got %b, required 1", settled); end
    held = data;
    do_sync(1'b1);
    n_checks++; if (settled !== 1'b0) begin n_fail++; $display("FAIL sync_settled: got %b, required 0", settled); end
    n_checks++; if (data !== held) begin n_fail++; $display("FAIL sync_data_hold: got %h, required %h", data, held); end
    w0 = n_words;
    for (int i = 0; i < 4 * R; i++) begin
      strobe(NUM_CH'($urandom), NUM_CH'($urandom), 4);
      if (i == 3 * R - 2) begin
        n_checks++; if (settled !== 1'b0) begin n_fail++; $display("FAIL sync_settle_early: got %b, required 0", settled); end
      end
    end
    repeat (4) tick();
    n_checks++; if (n_words - w0 != 1) begin n_fail++; $display("FAIL sync_word_count: got %0d, required 1", n_words - w0); end
  endtask

  task automatic test_sync_cancel();
    int w0;
    for (int i = 0; i < R && mctr != R - 1; i++) strobe(NUM_CH'($urandom), NUM_CH'($urandom), 4);
    w0 = n_words;
    strobe(NUM_CH'($urandom), NUM_CH'($urandom), 1);
    do_sync(1'b0);
    repeat (6) tick();
    n_checks++; if (n_words != w0) begin n_fail++; $display("FAIL cancel_in_flight: got %0d words, required 0", n_words - w0); end
    n_checks++; if (settled !== 1'b0) begin n_fail++; $display("FAIL cancel_settled: got %b, required 0", settled); end
  endtask

  task automatic test_reset_mid();
    int w0;
    do_sync(1'b0);
    for (int i = 0; i < 4 * R + R / 2; i++) strobe(NUM_CH'($urandom), NUM_CH'($urandom), 4);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (data !== '0)   begin n_fail++; $display("FAIL rstmid_data: got %h, required 0", data); end
    n_checks++; if (data_en !== 0) begin n_fail++; $display("FAIL rstmid_en: got %b, required 0", data_en); end
    n_checks++; if (settled !== 0) begin n_fail++; $display("FAIL rstmid_settled: got %b, required 0", settled); end
    sb.delete();
    model_clear();
    #3 rst = 1'b0;
    @(posedge clk); #1;
    w0 = n_words;
    for (int i = 0; i < 5 * R; i++)
      strobe(NUM_CH'($urandom), NUM_CH'($urandom), int'($urandom_range(3, 6)));
    repeat (4) tick();
    n_checks++; if (n_words - w0 != 2) begin n_fail++; $display("FAIL rstmid_word_count: got %0d, required 2", n_words - w0); end
  endtask

  initial begin
    for (int i = 0; i < R; i++)
      for (int j = 0; j < R; j++) t2[i+j] += 1;
    for (int i = 0; i < 2 * R - 1; i++)
      for (int j = 0; j < R; j++) h[i+j] += t2[i];

    test_reset();
    test_all_ones();
    test_opposite();
    test_toggle();
    test_random();
    test_sync();
    test_sync_cancel();
    test_reset_mid();

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d words outstanding, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
